// File: rtl/sram_bitstream_reader_pkg.sv
// Shared constants for the SRAM bitstream reader: default address width and
// FSM state encoding.
package sram_bitstream_reader_pkg;

  localparam int unsigned ADDR_WIDTH_DEF = 8;
  localparam int unsigned STATE_W        = 2;

  localparam logic [STATE_W-1:0] ST_IDLE    = 2'd0;
  localparam logic [STATE_W-1:0] ST_FETCH   = 2'd1;
  localparam logic [STATE_W-1:0] ST_PRESENT = 2'd2;
  localparam logic [STATE_W-1:0] ST_DONE    = 2'd3;

endpackage

// File: rtl/sram_bitstream_reader_if.sv
// Request, SRAM read-port and bit-stream handshake signals of the reader.
// The slave side is the reader itself; master is the requester/consumer/SRAM.
interface sram_bitstream_reader_if
  import sram_bitstream_reader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
);

  logic                  start;
  logic [ADDR_WIDTH-1:0] start_addr;
  logic [ADDR_WIDTH:0]   length;
  logic                  abort;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_data;
  logic                  bit_out;
  logic                  bit_valid;
  logic                  bit_ready;
  logic                  bit_last;
  logic                  busy;
  logic                  done;

  modport master (
    output start, start_addr, length, abort, rd_data, bit_ready,
    input  rd_addr, bit_out, bit_valid, bit_last, busy, done
  );

  modport slave (
    input  start, start_addr, length, abort, rd_data, bit_ready,
    output rd_addr, bit_out, bit_valid, bit_last, busy, done
  );

endinterface

// File: rtl/sram_bitstream_reader.sv
// Streams a run of bits out of a single-bit SRAM read port, one bit per cycle
// under a valid/ready handshake, with address wrap, length clamp and abort.
module sram_bitstream_reader
  import sram_bitstream_reader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input logic                   clk,
  input logic                   reset,
  sram_bitstream_reader_if.slave bus
);

  localparam int unsigned CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [STATE_W-1:0]    state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0]      remaining_q, remaining_d;
  logic                  bit_out_q, bit_out_d;
  logic                  bit_valid_q, bit_valid_d;
  logic                  bit_last_q, bit_last_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  capture;
  logic                  abort_hit;

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    remaining_d = remaining_q;
    bit_out_d   = bit_out_q;
    bit_valid_d = bit_valid_q;
    bit_last_d  = bit_last_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    capture     = 1'b0;
    abort_hit   = bus.abort && (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          ptr_d       = bus.start_addr;
          remaining_d = (bus.length > MAX_LEN) ? MAX_LEN : bus.length;
          busy_d      = 1'b1;
          if (bus.length == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_FETCH;
          end
        end
      end
      ST_FETCH: capture = 1'b1;
      ST_PRESENT: begin
        if (bus.bit_ready) begin
          if (remaining_q != '0) begin
            capture = 1'b1;
          end else begin
            state_d     = ST_DONE;
            bit_valid_d = 1'b0;
            bit_last_d  = 1'b0;
            done_d      = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d     = ST_IDLE;
        bit_valid_d = 1'b0;
        bit_last_d  = 1'b0;
        busy_d      = 1'b0;
      end
    endcase

    // Load the bit at ptr; remaining==1 here means this is the final bit.
    if (capture && !abort_hit) begin
      bit_out_d   = bus.rd_data;
      ptr_d       = ptr_q + ADDR_WIDTH'(1);
      remaining_d = remaining_q - CNT_W'(1);
      bit_valid_d = 1'b1;
      bit_last_d  = (remaining_q == CNT_W'(1));
      state_d     = ST_PRESENT;
    end

    // Abort outranks any handshake and suppresses the done pulse.
    if (abort_hit) begin
      state_d     = ST_IDLE;
      bit_valid_d = 1'b0;
      bit_last_d  = 1'b0;
      busy_d      = 1'b0;
      done_d      = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      remaining_q <= '0;
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
      bit_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      remaining_q <= remaining_d;
      bit_out_q   <= bit_out_d;
      bit_valid_q <= bit_valid_d;
      bit_last_q  <= bit_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.rd_addr   = ptr_q;
  assign bus.bit_out   = bit_out_q;
  assign bus.bit_valid = bit_valid_q;
  assign bus.bit_last  = bit_last_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule
